// File: rtl/pulse_train_generator_if.sv
// pulse_train_generator_if: start/length request and pulse/status response bundle; abort only with PULSE_TRAIN_ABORT_EN
interface pulse_train_generator_if #(parameter int HIGH_W = 8, parameter int LOW_W = 8, parameter int CNT_W = 8);
  logic start;
  logic [HIGH_W-1:0] high_len;
  logic [LOW_W-1:0] low_len;
  logic [CNT_W-1:0] count;
  logic ready;
  logic out;
  logic done;
  logic [CNT_W-1:0] pulses_left;
`ifdef PULSE_TRAIN_ABORT_EN
  logic abort;
  modport master(output abort, output start, high_len, low_len, count, input ready, out, done, pulses_left);
  modport slave(input abort, input start, high_len, low_len, count, output ready, out, done, pulses_left);
`else
  modport master(output start, high_len, low_len, count, input ready, out, done, pulses_left);
  modport slave(input start, high_len, low_len, count, output ready, out, done, pulses_left);
`endif
endinterface

// File: rtl/pulse_train_generator.sv
// pulse_train_generator: programmable train of count pulses, high_len high / low_len low; PULSE_TRAIN_ABORT_EN adds abort
module pulse_train_generator #(
  parameter int HIGH_W = 8,
  parameter int LOW_W = 8,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  pulse_train_generator_if.slave bus
);
  localparam int W = HIGH_W > LOW_W ? HIGH_W : LOW_W;
  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] phase, phase_n;
  logic [HIGH_W-1:0] h_m1;
  logic [LOW_W-1:0] l_m1;
  logic [CNT_W-1:0] left, left_n;
  logic ready, accept, last, kill;
  assign ready = state == IDLE || state == DONE;
  assign accept = bus.start & ready;
  assign last = left == CNT_W'(1);
`ifdef PULSE_TRAIN_ABORT_EN
  assign kill = bus.abort & ~ready;
`else
  assign kill = 1'b0;
`endif
  always_comb begin
    state_n = state;
    phase_n = phase + W'(1);
    left_n = left;
    case (state)
      IDLE, DONE: begin
        state_n = accept ? (bus.count == '0 ? DONE : HIGH) : IDLE;
        phase_n = '0;
        left_n = accept ? bus.count : '0;
      end
      HIGH: if (phase == W'(h_m1)) begin
        state_n = last ? DONE : LOW;
        phase_n = '0;
        left_n = last ? '0 : left;
      end
      LOW: if (phase == W'(l_m1)) begin
        state_n = HIGH;
        phase_n = '0;
        left_n = left - CNT_W'(1);
      end
      default: state_n = IDLE;
    endcase
    if (kill) begin
      state_n = IDLE;
      phase_n = '0;
      left_n = '0;
    end
  end
  // lengths are stored minus one so a zero length behaves as one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      h_m1 <= '0;
      l_m1 <= '0;
      left <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      left <= left_n;
      if (accept) begin
        h_m1 <= bus.high_len == '0 ? '0 : bus.high_len - HIGH_W'(1);
        l_m1 <= bus.low_len == '0 ? '0 : bus.low_len - LOW_W'(1);
      end
    end
  end
  assign bus.ready = ready;
  assign bus.out = state == HIGH;
  assign bus.done = state == DONE;
  assign bus.pulses_left = left;
endmodule

// File: tb/tb_pulse_train_generator.sv
// tb_pulse_train_generator: randomized trains checked against an arithmetic model of the expected waveform
module tb_pulse_train_generator;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pulse_train_generator_if bus();
  pulse_train_generator dut(.clk(clk), .rst(rst), .bus(bus.slave));

  function automatic logic [10:0] model(input int h, input int l, input int c, input int t);
    int hh, ll, p, len;
    hh = h == 0 ? 1 : h;
    ll = l == 0 ? 1 : l;
    p = hh + ll;
    len = c == 0 ? 0 : c * hh + (c - 1) * ll;
    if (t <= len) return {((t - 1) % p) < hh, 1'b0, 1'b0, 8'(c - (t - 1) / p)};
    return {1'b0, 1'b1, 1'b1, 8'd0};
  endfunction

  task automatic launch(input int h, input int l, input int c);
    total++;
    if (bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL launch_ready got=%b exp=1", bus.ready);
    end
    bus.start = 1'b1;
    bus.high_len = 8'(h);
    bus.low_len = 8'(l);
    bus.count = 8'(c);
  endtask

  task automatic run_train(input int h, input int l, input int c);
    int hh, ll, len;
    logic [10:0] act, exp;
    hh = h == 0 ? 1 : h;
    ll = l == 0 ? 1 : l;
    len = c == 0 ? 0 : c * hh + (c - 1) * ll;
    launch(h, l, c);
    for (int t = 1; t <= len + 1; t++) begin
      @(negedge clk);
      exp = model(h, l, c, t);
      act = {bus.out, bus.done, bus.ready, bus.pulses_left};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL train h=%0d l=%0d c=%0d t=%0d got{out,done,ready,left}=%h exp=%h", h, l, c, t, act, exp);
      end
      bus.start = t <= len ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.high_len = 8'($urandom);
      bus.low_len = 8'($urandom);
      bus.count = 8'($urandom);
    end
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      total++;
      if ({bus.out, bus.done, bus.ready, bus.pulses_left} !== 11'b00100000000) begin
        bad++;
        $display("FAIL idle got{out,done,ready,left}=%b%b%b_%h exp=001_00", bus.out, bus.done, bus.ready, bus.pulses_left);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.high_len = '0;
    bus.low_len = '0;
    bus.count = '0;
`ifdef PULSE_TRAIN_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    total++;
    if ({bus.out, bus.done, bus.ready, bus.pulses_left} !== 11'b00100000000) begin
      bad++;
      $display("FAIL reset got{out,done,ready,left}=%b%b%b_%h exp=001_00", bus.out, bus.done, bus.ready, bus.pulses_left);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_directed();
    run_train(2, 3, 3);
    idle(2);
    run_train(0, 0, 0);
    idle(1);
    run_train(0, 0, 2);
    idle(1);
  endtask

  task automatic test_back_to_back();
    run_train(1, 2, 2);
    run_train(3, 1, 1);
    run_train(2, 2, 0);
    run_train(1, 1, 2);
    idle(2);
  endtask

  task automatic test_full_range();
    run_train(255, 0, 2);
    run_train(1, 255, 2);
    idle(1);
  endtask

  task automatic test_random();
    repeat (25) begin
      run_train(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(1);
  endtask

  task automatic test_mid_reset();
    logic [10:0] act;
    launch(2, 3, 3);
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      act = {bus.out, bus.done, bus.ready, bus.pulses_left};
      total++;
      if (act !== model(2, 3, 3, t)) begin
        bad++;
        $display("FAIL mid_reset_pre t=%0d got=%h exp=%h", t, act, model(2, 3, 3, t));
      end
    end
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(15);
  endtask

`ifdef PULSE_TRAIN_ABORT_EN
  task automatic test_abort();
    logic [10:0] act;
    launch(2, 3, 3);
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      bus.start = 1'b0;
      act = {bus.out, bus.done, bus.ready, bus.pulses_left};
      total++;
      if (act !== model(2, 3, 3, t)) begin
        bad++;
        $display("FAIL abort_pre t=%0d got=%h exp=%h", t, act, model(2, 3, 3, t));
      end
    end
    bus.abort = 1'b1;
    idle(1);
    idle(1);
    bus.abort = 1'b0;
    idle(12);
    run_train(1, 1, 1);
    idle(1);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_full_range();
    test_random();
    test_mid_reset();
`ifdef PULSE_TRAIN_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
